// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - fetch stage bundle: imem request/response, redirect, decode backpressure, fetch group
interface fetch_if #(
    parameter int FETCH_WIDTH = 2,
    parameter int XLEN        = 32
) ();
    logic                              imem_req_valid;
    logic [XLEN-1:0]                   imem_req_addr;
    logic                              imem_req_ready;
    logic                              imem_resp_valid;
    logic [FETCH_WIDTH-1:0][XLEN-1:0]  imem_resp_instr;
    logic                              redirect_valid;
    logic [XLEN-1:0]                   redirect_pc;
    logic                              decode_stall;
    logic                              fetch_stall_req;
    logic [FETCH_WIDTH-1:0]            if_valid;
    logic [FETCH_WIDTH-1:0][XLEN-1:0]  if_pc;
    logic [FETCH_WIDTH-1:0][XLEN-1:0]  if_instr;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_instr,
        input  redirect_valid, redirect_pc,
        input  decode_stall, fetch_stall_req,
        output if_valid, if_pc, if_instr
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_instr,
        output redirect_valid, redirect_pc,
        output decode_stall, fetch_stall_req,
        input  if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: aligned group requests, redirect/drop handling, decode output register
module fetch #(
    parameter int              FETCH_WIDTH = 2,
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic    clk,
    input  logic    reset,
    fetch_if.master bus
);
    localparam int              OFF_W       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
    localparam logic [XLEN-1:0] GROUP_BYTES = XLEN'(FETCH_WIDTH * 4);
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~(GROUP_BYTES - XLEN'(1));

    typedef enum logic {S_REQ, S_WAIT} state_t;

    state_t                           state_q, state_d;
    logic [XLEN-1:0]                  pc_q, pc_d;
    logic                             drop_q, drop_d;
    logic [OFF_W-1:0]                 req_off_q, req_off_d;
    logic                             run_q;
    logic [FETCH_WIDTH-1:0]           vld_q, vld_d;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] lpc_q, lpc_d;
    logic [FETCH_WIDTH-1:0][XLEN-1:0] linstr_q, linstr_d;

    logic             stall;
    logic             out_free;
    logic             req_valid;
    logic             req_fire;
    logic [XLEN-1:0]  pc_aligned;
    logic [OFF_W-1:0] pc_off;

    assign stall      = bus.decode_stall | bus.fetch_stall_req;
    // A new request may go out only if its response will find the output register free.
    assign out_free   = (vld_q == '0) || !stall;
    assign pc_aligned = pc_q & ALIGN_MASK;
    assign pc_off     = (FETCH_WIDTH > 1) ? pc_q[2 +: OFF_W] : '0;
    // run_q keeps the request quiet until the first edge after reset release.
    assign req_valid  = run_q && (state_q == S_REQ) && out_free;
    assign req_fire   = req_valid && bus.imem_req_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = run_q ? pc_aligned : '0;
    assign bus.if_valid       = vld_q;
    assign bus.if_pc          = lpc_q;
    assign bus.if_instr       = linstr_q;

    // State, pc, drop flag and the decode output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            drop_q    <= 1'b0;
            req_off_q <= '0;
            run_q     <= 1'b0;
            vld_q     <= '0;
            lpc_q     <= '0;
            linstr_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            drop_q    <= drop_d;
            req_off_q <= req_off_d;
            run_q     <= 1'b1;
            vld_q     <= vld_d;
            lpc_q     <= lpc_d;
            linstr_q  <= linstr_d;
        end
    end

    // Next state: redirect first, then request handshake or response load/discard.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        drop_d    = drop_q;
        req_off_d = req_off_q;
        vld_d     = vld_q;
        lpc_d     = lpc_q;
        linstr_d  = linstr_q;

        if ((vld_q != '0) && !stall) begin
            vld_d = '0;
        end

        if (bus.redirect_valid) begin
            pc_d  = bus.redirect_pc;
            vld_d = '0;
            if (state_q == S_WAIT) begin
                // A coincident response is the stale one itself, so nothing remains to drop.
                if (bus.imem_resp_valid) begin
                    state_d = S_REQ;
                    drop_d  = 1'b0;
                end else begin
                    drop_d  = 1'b1;
                end
            end else if (req_fire) begin
                // The request leaving now targets the old path; its response must be dropped.
                state_d = S_WAIT;
                drop_d  = 1'b1;
            end
        end else begin
            case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d   = S_WAIT;
                        req_off_d = pc_off;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        state_d = S_REQ;
                        if (drop_q) begin
                            drop_d = 1'b0;
                        end else begin
                            for (int i = 0; i < FETCH_WIDTH; i++) begin
                                vld_d[i]    = (OFF_W'(i) >= req_off_q);
                                lpc_d[i]    = pc_aligned + XLEN'(4 * i);
                                linstr_d[i] = bus.imem_resp_instr[i];
                            end
                            pc_d = pc_aligned + GROUP_BYTES;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - randomized self-checking bench for fetch against a behavioural next-pc model
module tb_fetch;
    localparam int          FW  = 2;
    localparam int          XL  = 32;
    localparam logic [31:0] RPC = 32'h0;

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [31:0] in0;
    } ld_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_if #(.FETCH_WIDTH(FW), .XLEN(XL)) bus ();
    fetch #(.FETCH_WIDTH(FW), .XLEN(XL), .RESET_PC(RPC)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] align(input logic [31:0] a);
        return a & ~32'(FW * 4 - 1);
    endfunction

    function automatic logic [31:0] ifn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- behavioural model + per-cycle compare ----------------
    logic [31:0] m_pc;
    logic [1:0]  m_valid;
    logic [31:0] m_lpc [FW];
    logic        outst, out_stale, started, loaded_prev;
    logic [31:0] out_pc;
    ld_t         load_log[$];

    always @(negedge clk) begin : model
        logic stl, hs, rd, exp_rv, ld;
        logic [31:0] lane_pc;
        if (!rst_n) begin
            chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
            chk("rst_req_addr", bus.imem_req_addr, 32'd0);
            chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
            chk("rst_if_pc0", bus.if_pc[0], 32'd0);
            m_pc = RPC; m_valid = '0; outst = 0; out_stale = 0;
            started = 0; loaded_prev = 0;
        end else begin
            stl    = bus.decode_stall | bus.fetch_stall_req;
            exp_rv = started && !outst && (m_valid == 0 || !stl);
            chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
            if (bus.imem_req_valid) chk("req_addr", bus.imem_req_addr, align(m_pc));
            chk("if_valid", 32'(bus.if_valid), 32'(m_valid));
            for (int i = 0; i < FW; i++) begin
                if (m_valid[i]) begin
                    chk("if_pc", bus.if_pc[i], m_lpc[i]);
                    chk("if_instr", bus.if_instr[i], ifn(m_lpc[i]));
                end
            end
            if (loaded_prev)
                load_log.push_back({bus.if_valid, bus.if_pc[0], bus.if_pc[1], bus.if_instr[0]});

            hs = bus.imem_req_valid && bus.imem_req_ready;
            rd = bus.redirect_valid;
            ld = 0;
            if (bus.imem_resp_valid && outst) begin
                if (!rd && !out_stale) begin
                    for (int i = 0; i < FW; i++) begin
                        lane_pc    = align(out_pc) + 32'(4 * i);
                        m_valid[i] = (lane_pc >= out_pc);
                        m_lpc[i]   = lane_pc;
                    end
                    m_pc = align(out_pc) + 32'(FW * 4);
                    ld   = 1;
                end
                outst = 0;
            end else if (outst && rd) begin
                out_stale = 1;
            end
            if (hs) begin
                outst     = 1;
                out_pc    = m_pc;
                out_stale = rd;
            end
            if (rd) begin
                m_pc    = bus.redirect_pc;
                m_valid = '0;
                ld      = 0;
            end else if (!ld && m_valid != 0 && !stl) begin
                m_valid = '0;
            end
            loaded_prev = ld;
            started     = 1;
        end
    end

    // ---------------- driver with memory model ----------------
    logic        mem_pend;
    logic [31:0] mem_addr;
    int          mem_cnt, lat_min, lat_max, hs_cnt;
    logic [31:0] hs_log[$];

    task automatic cycle(input logic rdy, input logic stl, input logic rd, input logic [31:0] rdpc);
        logic dsel;
        @(negedge clk);
        if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
            hs_cnt++;
            hs_log.push_back(bus.imem_req_addr);
            mem_pend = 1;
            mem_addr = bus.imem_req_addr;
            mem_cnt  = int'($urandom_range(lat_min, lat_max)) - 1;
        end
        @(posedge clk);
        #1;
        bus.imem_resp_valid = 0;
        for (int i = 0; i < FW; i++) bus.imem_resp_instr[i] = $urandom;
        if (mem_pend) begin
            if (mem_cnt == 0) begin
                bus.imem_resp_valid = 1;
                for (int i = 0; i < FW; i++) bus.imem_resp_instr[i] = ifn(mem_addr + 32'(4 * i));
                mem_pend = 0;
            end else begin
                mem_cnt--;
            end
        end
        dsel                = 1'($urandom_range(0, 1));
        bus.imem_req_ready  = rdy;
        bus.decode_stall    = stl & dsel;
        bus.fetch_stall_req = stl & ~dsel;
        bus.redirect_valid  = rd;
        bus.redirect_pc     = rdpc;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        mem_pend = 0; hs_cnt = 0;
        hs_log.delete();
        load_log.delete();
        bus.imem_req_ready = 0; bus.imem_resp_valid = 0; bus.imem_resp_instr = '0;
        bus.redirect_valid = 0; bus.redirect_pc = '0;
        bus.decode_stall = 0; bus.fetch_stall_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    function automatic logic [31:0] hs_at(input int i);
        if (i < hs_log.size()) return hs_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic ld_t ld_at(input int i);
        ld_t z;
        z = '1;
        if (i < load_log.size()) return load_log[i];
        return z;
    endfunction

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int n, stall_left;
        logic stl;
        logic [31:0] rdpc;
        lat_min = 1; lat_max = 1;
        apply_reset();

        // back-to-back groups with 1-cycle memory
        repeat (10) cycle(1, 0, 0, 0);
        chk("p1_hs0", hs_at(0), 32'h0);
        chk("p1_hs1", hs_at(1), 32'h8);
        chk("p1_hs2", hs_at(2), 32'h10);
        chk("p1_ld0_valid", 32'(ld_at(0).v), 32'h3);
        chk("p1_ld0_pc0", ld_at(0).pc0, 32'h0);
        chk("p1_ld0_pc1", ld_at(0).pc1, 32'h4);
        chk("p1_ld0_in0", ld_at(0).in0, ifn(32'h0));
        chk("p1_ld1_pc0", ld_at(1).pc0, 32'h8);
        chk("p1_ld1_pc1", ld_at(1).pc1, 32'hC);

        // group 0x8 arrives under stall and is held
        apply_reset();
        for (int k = 0; k < 20 && hs_cnt < 2; k++) cycle(1, 0, 0, 0);
        repeat (5) cycle(1, 1, 0, 0);
        chk("p2_no_req_while_stalled", 32'(hs_cnt), 32'd2);
        chk("p2_held_valid", 32'(bus.if_valid), 32'h3);
        chk("p2_held_pc0", bus.if_pc[0], 32'h8);
        for (int k = 0; k < 20 && hs_cnt < 3; k++) cycle(1, 0, 0, 0);
        chk("p2_next_addr", hs_at(2), 32'h10);

        // redirect to 0x104 while waiting on 0x10
        apply_reset();
        lat_min = 3; lat_max = 3;
        for (int k = 0; k < 30 && hs_cnt < 3; k++) cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 32'h104);
        for (int k = 0; k < 40 && hs_cnt < 5; k++) cycle(1, 0, 0, 0);
        chk("p3_redir_addr", hs_at(3), 32'h100);
        chk("p3_follow_addr", hs_at(4), 32'h108);
        chk("p3_mid_valid", 32'(ld_at(2).v), 32'h2);
        chk("p3_mid_pc1", ld_at(2).pc1, 32'h104);

        // redirect coincident with the 0x108 response
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 32'h208);
        for (int k = 0; k < 40 && hs_cnt < 7; k++) cycle(1, 0, 0, 0);
        chk("p4_redir_addr", hs_at(5), 32'h208);
        chk("p4_follow_addr", hs_at(6), 32'h210);
        chk("p4_ld_valid", 32'(ld_at(3).v), 32'h3);
        chk("p4_ld_pc0", ld_at(3).pc0, 32'h208);

        // ready held low, request must wait
        lat_min = 1; lat_max = 1;
        n = hs_cnt;
        repeat (8) cycle(0, 0, 0, 0);
        chk("p5_no_hs_not_ready", 32'(hs_cnt), 32'(n));
        chk("p5_req_pending", 32'(bus.imem_req_valid), 32'd1);
        chk("p5_req_addr", bus.imem_req_addr, 32'h218);
        cycle(1, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        chk("p5_single_hs", 32'(hs_cnt), 32'(n + 1));

        // async reset while a group is held
        repeat (4) cycle(1, 1, 0, 0);
        chk("p6_pre_held", 32'(bus.if_valid), 32'h3);
        #2 rst_n = 0;
        #1;
        chk("p6_async_if_valid", 32'(bus.if_valid), 32'd0);
        chk("p6_async_req_valid", 32'(bus.imem_req_valid), 32'd0);
        apply_reset();
        for (int k = 0; k < 10 && hs_cnt < 1; k++) cycle(1, 0, 0, 0);
        chk("p6_first_addr", hs_at(0), RPC);

        // randomized traffic
        apply_reset();
        lat_min = 1; lat_max = 4;
        stall_left = 0;
        for (int k = 0; k < 3000; k++) begin
            if (stall_left > 0) begin
                stall_left--; stl = 1;
            end else begin
                stl = 0;
                if ($urandom_range(0, 7) == 0) stall_left = int'($urandom_range(1, 5));
            end
            if ($urandom_range(0, 7) == 0) rdpc = 32'hFFFF_FFF0 | (32'($urandom) & 32'hC);
            else rdpc = 32'($urandom_range(0, 255)) << 2;
            cycle(($urandom_range(0, 3) != 0), stl, ($urandom_range(0, 19) == 0), rdpc);
        end
        chk("rand_progress", 32'(hs_cnt > 300), 32'd1);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
